// File: rtl/freelist_ctrl.sv
// Physical-register free list for the 4-wide rename stage, with flush rollback.
// Define FREELIST_CHECK_EN for sticky overflow / over-commit detection on o_err.
module freelist_ctrl #(
    parameter int WIDTH     = 6,
    parameter int ARCH_REGS = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_allocReq,
    input  logic               i_allocEn,
    output logic [4*WIDTH-1:0] o_allocAddr4x,
    output logic               o_stall,
    output logic [4*WIDTH-1:0] o_busySet4x,
    input  logic [3:0]         i_freeVld,
    input  logic [4*WIDTH-1:0] i_freeAddr4x,
    input  logic [2:0]         i_commitCnt,
    input  logic               i_flush,
    output logic [WIDTH:0]     o_count,
    output logic               o_err
);

    localparam int DEPTH = 1 << WIDTH;
    localparam int PW    = WIDTH + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    commit_head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    count;
    logic [PW-1:0]    commit_next;
    logic [2:0]       n_req;
    logic [2:0]       n_free;
    logic [2:0]       req_ofs  [4];
    logic [2:0]       free_ofs [4];
    logic [3:0]       free_ok;
    logic             fire;
    logic             wr_en;

    // Lane offsets give the compacted slot of each requesting / freeing lane
    always_comb begin
        n_req  = '0;
        n_free = '0;
        free_ok = '0;
        for (int j = 0; j < 4; j++) begin
            req_ofs[j]  = n_req;
            free_ofs[j] = n_free;
            free_ok[j]  = i_freeVld[j] &&
                          (i_freeAddr4x[j*WIDTH +: WIDTH] != '0);
            n_req  = n_req + {2'b0, i_allocReq[j]};
            n_free = n_free + {2'b0, free_ok[j]};
        end
    end

    always_comb begin
        o_allocAddr4x = '0;
        for (int j = 0; j < 4; j++) begin
            if (i_allocReq[j]) begin
                o_allocAddr4x[j*WIDTH +: WIDTH] =
                    mem[head[WIDTH-1:0] + WIDTH'(req_ofs[j])];
            end
        end
    end

    assign count       = tail - head;
    assign o_count     = count;
    assign o_stall     = PW'(n_req) > count;
    assign fire        = i_allocEn && !o_stall && !i_flush;
    assign o_busySet4x = fire ? o_allocAddr4x : '0;
    assign commit_next = commit_head + PW'(i_commitCnt);

`ifdef FREELIST_CHECK_EN
    logic ovf;
    logic bad_commit;
    logic err;

    assign ovf        = (count + PW'(n_free)) > PW'(DEPTH);
    assign bad_commit = PW'(i_commitCnt) > (head - commit_head);
    assign wr_en      = !ovf;
    assign o_err      = err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= 1'b0;
        end else if (ovf || bad_commit) begin
            err <= 1'b1;
        end
    end
`else
    assign wr_en = 1'b1;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= PW'(DEPTH - ARCH_REGS);
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < DEPTH - ARCH_REGS) ?
                          WIDTH'(ARCH_REGS + i) : '0;
            end
        end else begin
            commit_head <= commit_next;
            // Flush rolls speculation back to the post-commit head
            if (i_flush) begin
                head <= commit_next;
            end else if (fire) begin
                head <= head + PW'(n_req);
            end
            if (wr_en) begin
                for (int j = 0; j < 4; j++) begin
                    if (free_ok[j]) begin
                        mem[tail[WIDTH-1:0] + WIDTH'(free_ofs[j])] <=
                            i_freeAddr4x[j*WIDTH +: WIDTH];
                    end
                end
                tail <= tail + PW'(n_free);
            end
        end
    end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed plus randomized check of freelist_ctrl against a queue-based model.
// The model tracks tags from the committed head onward plus a speculative depth.
module tb_freelist_ctrl;

    localparam int W     = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic          en;
    logic [4*W-1:0] alloc;
    logic          stall;
    logic [4*W-1:0] busy;
    logic [3:0]    fvld;
    logic [4*W-1:0] faddr;
    logic [2:0]    ccnt;
    logic          flush;
    logic [W:0]    count;
    logic          err;

    int vectors = 0;
    int miscompares = 0;
    int q[$];
    int spec;
    bit err_m;

    always #5 clk = ~clk;

    freelist_ctrl #(.WIDTH(W), .ARCH_REGS(32)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_allocReq(req),
        .i_allocEn(en),
        .o_allocAddr4x(alloc),
        .o_stall(stall),
        .o_busySet4x(busy),
        .i_freeVld(fvld),
        .i_freeAddr4x(faddr),
        .i_commitCnt(ccnt),
        .i_flush(flush),
        .o_count(count),
        .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic e,
                         input logic [3:0] fv, input logic [4*W-1:0] fa,
                         input logic [2:0] cc, input logic fl);
        req = r; en = e; fvld = fv; faddr = fa; ccnt = cc; flush = fl;
    endtask

    task automatic do_reset();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int i = 32; i < 64; i++) q.push_back(i);
        spec = 0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One cycle: predict, check at negedge, then advance the model
    task automatic step();
        int nreq, cnt, k;
        int fl[$];
        logic [4*W-1:0] ea;
        logic st, fire;
        nreq = $countones(req);
        cnt = q.size() - spec;
        st = nreq > cnt;
        ea = '0;
        if (!st) begin
            k = 0;
            for (int j = 0; j < 4; j++) begin
                if (req[j]) begin
                    ea[j*W +: W] = W'(q[spec + k]);
                    k++;
                end
            end
        end
        fire = en && !st && !flush;
        @(negedge clk);
        chk("count", 32'(count), 32'(cnt));
        chk("stall", 32'(stall), 32'(st));
        if (!st) chk("alloc", 32'(alloc), 32'(ea));
        chk("busy", 32'(busy), fire ? 32'(ea) : 32'd0);
        chk("err", 32'(err), 32'(err_m));
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            if (fvld[j] && faddr[j*W +: W] != '0) fl.push_back(int'(faddr[j*W +: W]));
        end
`ifdef FREELIST_CHECK_EN
        if (cnt + fl.size() > DEPTH) err_m = 1'b1;
        else foreach (fl[i]) q.push_back(fl[i]);
        if (int'(ccnt) > spec) err_m = 1'b1;
`else
        foreach (fl[i]) q.push_back(fl[i]);
`endif
        if (fire) spec += nreq;
        repeat (int'(ccnt)) void'(q.pop_front());
        spec -= int'(ccnt);
        if (flush) spec = 0;
    endtask

    initial begin
        // Four-lane allocation straight out of reset
        do_reset();
        drive(4'b1111, 1'b1, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_lanes", 32'(alloc), 32'({6'd35, 6'd34, 6'd33, 6'd32}));
        chk("plan_busy", 32'(busy), 32'({6'd35, 6'd34, 6'd33, 6'd32}));
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_cnt28", 32'(count), 32'd28);
        step();

        // Sparse lanes
        do_reset();
        drive(4'b1010, 1'b1, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_sparse", 32'(alloc), 32'({6'd33, 6'd0, 6'd32, 6'd0}));
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_cnt30", 32'(count), 32'd30);
        step();

        // Drain to 2, stall with concurrent free, then fire
        repeat (7) begin
            drive(4'b1111, 1'b1, 4'b0, '0, 3'd0, 1'b0);
            step();
        end
        drive(4'b0111, 1'b1, 4'b0011, {6'd0, 6'd0, 6'd6, 6'd5}, 3'd0, 1'b0);
        #1;
        chk("plan_stall", 32'(stall), 32'd1);
        step();
        drive(4'b0111, 1'b1, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_cnt4", 32'(count), 32'd4);
        chk("plan_nostall", 32'(stall), 32'd0);
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_cnt1", 32'(count), 32'd1);
        step();

        // Commit 3 of 8, flush, re-allocate
        do_reset();
        repeat (2) begin
            drive(4'b1111, 1'b1, 4'b0, '0, 3'd0, 1'b0);
            step();
        end
        drive(4'b0, 1'b0, 4'b0, '0, 3'd3, 1'b0);
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b1);
        step();
        drive(4'b0001, 1'b1, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_flush_tag", 32'(alloc), 32'd35);
        chk("plan_cnt29", 32'(count), 32'd29);
        step();

        // Free with zero tags mixed in
        do_reset();
        drive(4'b0, 1'b0, 4'b1111, {6'd41, 6'd0, 6'd40, 6'd0}, 3'd0, 1'b0);
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_cnt34", 32'(count), 32'd34);
        step();
        repeat (8) begin
            drive(4'b1111, 1'b1, 4'b0, '0, 3'd0, 1'b0);
            step();
        end
        drive(4'b0011, 1'b1, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_freed", 32'(alloc), 32'({6'd0, 6'd0, 6'd41, 6'd40}));
        step();

`ifdef FREELIST_CHECK_EN
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b0, 1'b0, 4'b1111,
                  {6'(4*c+4), 6'(4*c+3), 6'(4*c+2), 6'(4*c+1)}, 3'd0, 1'b0);
            step();
        end
        drive(4'b0, 1'b0, 4'b0001, {18'd0, 6'd5}, 3'd0, 1'b0);
        step();
        drive(4'b0, 1'b0, 4'b0, '0, 3'd0, 1'b0);
        #1;
        chk("plan_err", 32'(err), 32'd1);
        chk("plan_cnt64", 32'(count), 32'd64);
        step();
        step();
`endif

        // Random traffic with commits, flushes, wrap and a mid-run reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r, fv;
            logic [4*W-1:0] fa;
            int lim, nf;
            if (i == 300) do_reset();
            r = 4'($urandom);
            fv = 4'($urandom);
            fa = '0;
            nf = 0;
            for (int j = 0; j < 4; j++) begin
                fa[j*W +: W] = ($urandom_range(7, 0) == 0) ? 6'd0 :
                               6'($urandom_range(63, 1));
                if (fv[j] && fa[j*W +: W] != '0) nf++;
            end
            if (q.size() + nf > DEPTH) fv = 4'b0;
            lim = (spec < 4) ? spec : 4;
            drive(r, ($urandom_range(3, 0) != 0), fv, fa,
                  3'($urandom_range(lim, 0)), ($urandom_range(15, 0) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
